// File: rtl/xbee_pkg.sv
// xbee_pkg: XBee API framing constants and transmit FSM state encoding.
package xbee_pkg;
    localparam logic [7:0]  START_DELIM = 8'h7E;
    localparam logic [7:0]  API_TX_REQ  = 8'h10;
    localparam logic [7:0]  API_RX_PKT  = 8'h90;
    localparam logic [7:0]  ESC_BYTE    = 8'h7D;
    localparam logic [7:0]  ESC_MASK    = 8'h20;
    localparam logic [7:0]  XON         = 8'h11;
    localparam logic [7:0]  XOFF        = 8'h13;
    localparam logic [15:0] FRAME_LEN   = 16'h0010;
    localparam logic [4:0]  LAST_IDX    = 5'd19;

    typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, DONE} state_t;

    function automatic logic needs_escape(input logic [7:0] b);
        return b == START_DELIM || b == ESC_BYTE || b == XON || b == XOFF;
    endfunction
endpackage

// File: rtl/xbee_rr_arbiter.sv
// xbee_rr_arbiter: 2-way round-robin grant; the pointer favours the requester not granted last.
module xbee_rr_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic ptr;

    always_comb begin
        grant[0] = enable && valid[0] && (!valid[1] || !ptr);
        grant[1] = enable && valid[1] && (!valid[0] || ptr);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        ptr <= 1'b0;
        else if (grant[0]) ptr <= 1'b1;
        else if (grant[1]) ptr <= 1'b0;
    end
endmodule

// File: rtl/xbee_tx_arbiter.sv
// xbee_tx_arbiter: shares one UART between two requesters, wrapping payloads in XBee 0x10 frames.
// Define XBEE_TX_ESCAPE_EN for API mode 2 byte escaping.
module xbee_tx_arbiter
    import xbee_pkg::*;
#(
    parameter logic [63:0] DEST_ADDR64 = 64'h0000_0000_0000_FFFF,
    parameter logic [15:0] DEST_ADDR16 = 16'hFFFE,
    parameter logic [7:0]  RADIUS      = 8'h00,
    parameter logic [7:0]  OPTIONS     = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ack,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ack,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic [7:0]  last_frame_id
);
    state_t       state;
    logic [4:0]   idx;
    logic [7:0]   frame_id;
    logic [7:0]   sum;
    logic [7:0]   raw;
    logic [15:0]  payload;
    logic [1:0]   grant;
    logic [159:0] frame;
    logic         need_esc;
    logic         esc_phase;

    // The checksum slot reads the running sum, which is complete by the time idx reaches it.
    assign frame = {START_DELIM, FRAME_LEN, API_TX_REQ, frame_id, DEST_ADDR64, DEST_ADDR16,
                    RADIUS, OPTIONS, payload, 8'hFF - sum};
    assign raw   = frame[8*(19-int'(idx)) +: 8];

`ifdef XBEE_TX_ESCAPE_EN
    assign need_esc = idx != 5'd0 && needs_escape(raw);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                        esc_phase <= 1'b0;
        else if (state == WAIT_LO && !tx_busy && need_esc) esc_phase <= !esc_phase;
    end
`else
    assign need_esc  = 1'b0;
    assign esc_phase = 1'b0;
`endif

    xbee_rr_arbiter u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (state == IDLE && !tx_busy),
        .valid  ({req1_valid, req0_valid}),
        .grant  (grant)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            idx           <= 5'd0;
            sum           <= 8'h00;
            payload       <= 16'h0000;
            frame_id      <= 8'h01;
            req0_ack      <= 1'b0;
            req1_ack      <= 1'b0;
            tx_byte       <= 8'h00;
            tx_start      <= 1'b0;
            busy          <= 1'b0;
            last_frame_id <= 8'h00;
        end else begin
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                IDLE: if (|grant) begin
                    payload  <= grant[0] ? req0_data : req1_data;
                    req0_ack <= grant[0];
                    req1_ack <= grant[1];
                    busy     <= 1'b1;
                    idx      <= 5'd0;
                    sum      <= 8'h00;
                    state    <= SEND;
                end
                SEND: begin
                    tx_byte  <= esc_phase ? raw ^ ESC_MASK : need_esc ? ESC_BYTE : raw;
                    tx_start <= 1'b1;
                    state    <= WAIT_HI;
                end
                WAIT_HI: if (tx_busy) state <= WAIT_LO;
                WAIT_LO: if (!tx_busy) begin
                    if (need_esc && !esc_phase) state <= SEND;
                    else if (idx == LAST_IDX)   state <= DONE;
                    else begin
                        if (idx >= 5'd3) sum <= sum + raw;
                        idx   <= idx + 5'd1;
                        state <= SEND;
                    end
                end
                DONE: begin
                    last_frame_id <= frame_id;
                    frame_id      <= frame_id == 8'hFF ? 8'h01 : frame_id + 8'h01;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/xbee_tx_arbiter.md
Name: xbee_tx_arbiter

Overview:
- Shares the single UART transmitter between two on-chip requesters, for example the telemetry source and the command-acknowledge source.
- Wraps each granted 2-byte payload in an XBee API Transmit Request frame (API ID 0x10) and sequences it byte-by-byte into the UART.
- Is the transmit-side counterpart of the 0x90 receive-frame parser; both sit between `uart` and the motor/LED control logic.

Parameters:
- DEST_ADDR64, 64'h0000_0000_0000_FFFF: 64-bit destination address (broadcast by default).
- DEST_ADDR16, 16'hFFFE: 16-bit destination network address.
- RADIUS, 8'h00: broadcast radius byte.
- OPTIONS, 8'h00: transmit options byte.

Ports:
- clock  in  1: single clock domain for the whole block.
- reset  in  1: asynchronous, active-low reset (asserted when 0).
- req0_valid  in  1: requester 0 has a payload waiting.
- req0_data  in  16: requester 0 payload; [15:8] is sent first.
- req0_ack  out  1: one-cycle pulse when req0_data is captured.
- req1_valid  in  1: requester 1 has a payload waiting.
- req1_data  in  16: requester 1 payload; [15:8] is sent first.
- req1_ack  out  1: one-cycle pulse when req1_data is captured.
- tx_byte  out  8: byte presented to the UART transmitter.
- tx_start  out  1: one-cycle strobe that launches tx_byte.
- tx_busy  in  1: UART transmitter is busy.
- busy  out  1: high from grant until the last byte has completed.
- last_frame_id  out  8: frame ID of the most recently completed frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; frame-ID counter 8'h01; round-robin pointer favours req0. Reset asserted mid-frame aborts the frame immediately, and no further tx_start is issued.
- Frame is 20 bytes, index 0..19, in this order:
  - 0x7E, 0x00, 0x10
  - 0x10, frame ID
  - DEST_ADDR64 MSB first (8 bytes)
  - DEST_ADDR16 MSB first (2 bytes)
  - RADIUS, OPTIONS
  - payload[15:8], payload[7:0]
  - checksum
- Checksum = 8'hFF minus the 8-bit sum of bytes 3..18 (carries discarded). It is accumulated while bytes are sent, not precomputed.
- Arbitration in IDLE:
  - Only when tx_busy=0.
  - One requester valid: it wins.
  - Both valid: the requester not granted last wins.
  - Granted ack pulses for exactly 1 cycle, and the payload is latched in that same cycle.
  - The pointer toggles to the other requester after each grant.
  - A requester keeps valid high until its ack. Data changing after the ack has no effect on the frame.
- State machine:
  - IDLE -> SEND on grant.
  - SEND: drive tx_byte, tx_start=1 for 1 cycle, then -> WAIT_HI.
  - WAIT_HI: wait for tx_busy=1, then -> WAIT_LO.
  - WAIT_LO: wait for tx_busy=0. If index=19 -> DONE, else index+1 and -> SEND.
  - DONE, 1 cycle: last_frame_id <= frame ID; frame ID increments, wrapping 0xFF -> 0x01 (0x00 is never used); -> IDLE.
- tx_byte stays stable from SEND until tx_busy falls.
- busy is high from the grant cycle through DONE inclusive.
- Minimum gap between frames is 1 idle cycle. Requests arriving while busy wait; no request is dropped.

Optional Feature:
- Macro: XBEE_TX_ESCAPE_EN.
- Defined (API mode 2):
  - Any byte after index 0 equal to 0x7E, 0x7D, 0x11 or 0x13 is sent as 0x7D followed by (byte XOR 0x20).
  - The escape pair uses two full SEND/WAIT handshakes.
  - Checksum and length cover unescaped values only.
  - The index advances only after the second byte of a pair.
- Undefined (API mode 1): bytes are sent raw and the escape logic is absent.

Decomposition:
- Package xbee_pkg:
  - Start delimiter 8'h7E.
  - API IDs 8'h10 and 8'h90.
  - Escape byte 8'h7D, XOR mask 8'h20, XON 8'h11, XOFF 8'h13.
  - Frame length 16'h0010.
  - State encoding.
- Sub-module xbee_rr_arbiter: 2-way round-robin grant with a pointer register, shared with future multi-source blocks.

Test Plan:
- Single request: req0 with 16'h1234, frame ID 1, default parameters -> bytes 7E 00 10 10 01 00 00 00 00 00 00 FF FF FF FE 00 00 12 34 AD. req0_ack pulses once and last_frame_id=01.
- Contention: req0 and req1 valid in the same cycle after reset -> req0 framed first, then req1. With both held continuously, grants alternate 0,1,0,1.
- Frame ID wrap: 255 consecutive frames -> IDs run 01..FF, then the next frame uses 01, never 00.
- Handshake: tx_busy held high 5 cycles before its rising edge after each tx_start -> exactly one tx_start per byte and tx_byte stable throughout.
- Reset mid-frame: reset pulled low at byte index 9 -> outputs 0 and state IDLE immediately. After release, a pending req1 sends a complete new frame with ID 01.
- With XBEE_TX_ESCAPE_EN defined: payload 16'h7E11 -> payload bytes sent as 7D 5E 7D 31. Checksum is computed over the unescaped 7E 11, and the first byte 7E is not escaped.
